reg_file_32: RTL

//  - MIPS general-purpose register file; sits directly downstream of the writeback 2:1 32-bit mux.
//  - The writeback mux output (ALU result vs. memory data) drives wr_data here.
//  - Provides two combinational read ports (rs, rt) to decode/ALU and one clocked write port.
//  - Register $0 is hardwired to zero.

---
 rtl/reg_file_32_if.sv | 29 ++
 rtl/reg_file_32.sv | 71 +++++++
 2 files changed

// File: rtl/reg_file_32_if.sv
// Register file access bus: two combinational read ports and one write port.
// Ports (master = decode/writeback side, slave = register file):
//   rd_addr1/rd_addr2  read addresses (rs, rt)       master -> slave
//   rd_data1/rd_data2  read data                     slave  -> master
//   wr_en              write enable (RegWrite)       master -> slave
//   wr_addr            write address (RegDst mux)    master -> slave
//   wr_data            write data (writeback mux)    master -> slave
interface reg_file_32_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
      input  rd_data1, rd_data2
   );

   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
      output rd_data1, rd_data2
   );
endinterface

// File: rtl/reg_file_32.sv
// MIPS general-purpose register file, 2**ADDR_W x DATA_W, $0 hardwired to zero.
// Ports:
//   clk    rising-edge clock for all state updates
//   rst_n  synchronous active-low reset, clears every register, beats writes
//   bus    reg_file_32_if.slave: two combinational read ports, one clocked write port
// Optional feature: define RF_WRITE_BYPASS_EN to forward wr_data onto a read
// port that addresses the register being written in the same cycle.
module reg_file_32 #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   reg_file_32_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              wr_hit;

   // Writes to $0 are dropped here so the zero register never changes.
   assign wr_hit = bus.wr_en && (bus.wr_addr != ADDR_W'(0));

   // Next-state: only the addressed register takes the write data.
   always_comb begin
      regs_d = regs_q;
      if (wr_hit) begin
         regs_d[bus.wr_addr] = bus.wr_data;
      end
   end

   // Storage with synchronous reset taking priority over any write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read port 1: $0 override applied last so it also wins over bypass.
   always_comb begin
      bus.rd_data1 = regs_q[bus.rd_addr1];
`ifdef RF_WRITE_BYPASS_EN
      if (rst_n && wr_hit && (bus.wr_addr == bus.rd_addr1)) begin
         bus.rd_data1 = bus.wr_data;
      end
`endif
      if (bus.rd_addr1 == ADDR_W'(0)) begin
         bus.rd_data1 = '0;
      end
   end

   // Read port 2: same structure as port 1.
   always_comb begin
      bus.rd_data2 = regs_q[bus.rd_addr2];
`ifdef RF_WRITE_BYPASS_EN
      if (rst_n && wr_hit && (bus.wr_addr == bus.rd_addr2)) begin
         bus.rd_data2 = bus.wr_data;
      end
`endif
      if (bus.rd_addr2 == ADDR_W'(0)) begin
         bus.rd_data2 = '0;
      end
   end

endmodule
